wb_stage_slice: RTL and testbench

- Parametrised Wishbone register slice for timing closure at interconnect boundaries.
- Request and response are registered. Widths are generic; the response path can be registered or bypassed.
- Issue/burst/drain is controlled by an explicit FSM, so a stale master strobe is never re-issued.
- Sits between a Wishbone master port and an interconnect or slave port in the riscduino fabric.

---
 rtl/wb_stage_slice.sv | 195 +++++++++++++++++++
 tb/tb_wb_stage_slice.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_slice.sv
// Wishbone register slice: registered request path, optional registered response path.
// Optional slave no-ack timeout enabled by defining WB_STAGE_TMO_EN.
module wb_stage_slice #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int BLW     = 10,
  parameter int TIDW    = 4,
  parameter int RSP_REG = 1,
  parameter int TMO_CYC = 256
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [DW-1:0]     m_wbd_dat_i,
  input  logic [AW-1:0]     m_wbd_adr_i,
  input  logic [DW/8-1:0]   m_wbd_sel_i,
  input  logic [BLW-1:0]    m_wbd_bl_i,
  input  logic              m_wbd_bry_i,
  input  logic              m_wbd_we_i,
  input  logic              m_wbd_cyc_i,
  input  logic              m_wbd_stb_i,
  input  logic [TIDW-1:0]   m_wbd_tid_i,
  output logic [DW-1:0]     m_wbd_dat_o,
  output logic              m_wbd_ack_o,
  output logic              m_wbd_lack_o,
  output logic              m_wbd_err_o,
  input  logic [DW-1:0]     s_wbd_dat_i,
  input  logic              s_wbd_ack_i,
  input  logic              s_wbd_lack_i,
  input  logic              s_wbd_err_i,
  output logic [DW-1:0]     s_wbd_dat_o,
  output logic [AW-1:0]     s_wbd_adr_o,
  output logic [DW/8-1:0]   s_wbd_sel_o,
  output logic [BLW-1:0]    s_wbd_bl_o,
  output logic              s_wbd_bry_o,
  output logic              s_wbd_we_o,
  output logic              s_wbd_cyc_o,
  output logic              s_wbd_stb_o,
  output logic [TIDW-1:0]   s_wbd_tid_o
);

  typedef enum logic [1:0] {IDLE, ACTIVE, REFILL, DRAIN} state_t;

  state_t state, state_nxt;
  logic   refill_hold, refill_hold_nxt;
  logic   load_req, load_beat, clr_bry, clr_req;
  logic   end_xfer, busy;
  logic   tmo_hit, tmo_err;

  if (TMO_CYC < 2) begin : g_bad_tmo
    $error("wb_stage_slice: TMO_CYC must be at least 2");
  end

  assign busy     = (state == ACTIVE) || (state == REFILL);
  assign end_xfer = s_wbd_lack_i || s_wbd_err_i || tmo_hit;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      refill_hold <= 1'b0;
    end else begin
      // NOTE: every clocked assignment is non-blocking so all flops update from pre-edge values.
      state       <= state_nxt;
      refill_hold <= refill_hold_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    state_nxt       = state;
    refill_hold_nxt = 1'b0;
    load_req        = 1'b0;
    load_beat       = 1'b0;
    clr_bry         = 1'b0;
    clr_req         = 1'b0;
    unique case (state)
      IDLE: begin
        if (m_wbd_stb_i && m_wbd_cyc_i && m_wbd_bry_i) begin
          load_req  = 1'b1;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (end_xfer) begin
          clr_req   = 1'b1;
          state_nxt = (RSP_REG != 0) ? DRAIN : IDLE;
        end else if (s_wbd_ack_i) begin
          clr_bry         = 1'b1;
          refill_hold_nxt = (RSP_REG != 0);
          state_nxt       = REFILL;
        end
      end
      REFILL: begin
        // With a registered response the master sees the ack one cycle late, so skip that cycle.
        if (end_xfer) begin
          clr_req   = 1'b1;
          state_nxt = (RSP_REG != 0) ? DRAIN : IDLE;
        end else if (!refill_hold && m_wbd_stb_i && m_wbd_bry_i) begin
          load_beat = 1'b1;
          state_nxt = ACTIVE;
        end
      end
      DRAIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      s_wbd_dat_o <= '0;
      s_wbd_adr_o <= '0;
      s_wbd_sel_o <= '0;
      s_wbd_bl_o  <= '0;
      s_wbd_bry_o <= 1'b0;
      s_wbd_we_o  <= 1'b0;
      s_wbd_cyc_o <= 1'b0;
      s_wbd_stb_o <= 1'b0;
      s_wbd_tid_o <= '0;
    end else if (load_req) begin
      s_wbd_dat_o <= m_wbd_dat_i;
      s_wbd_adr_o <= m_wbd_adr_i;
      s_wbd_sel_o <= m_wbd_sel_i;
      s_wbd_bl_o  <= m_wbd_bl_i;
      s_wbd_bry_o <= 1'b1;
      s_wbd_we_o  <= m_wbd_we_i;
      s_wbd_cyc_o <= 1'b1;
      s_wbd_stb_o <= 1'b1;
      s_wbd_tid_o <= m_wbd_tid_i;
    end else if (clr_req) begin
      s_wbd_dat_o <= '0;
      s_wbd_adr_o <= '0;
      s_wbd_sel_o <= '0;
      s_wbd_bl_o  <= '0;
      s_wbd_bry_o <= 1'b0;
      s_wbd_we_o  <= 1'b0;
      s_wbd_cyc_o <= 1'b0;
      s_wbd_stb_o <= 1'b0;
      s_wbd_tid_o <= '0;
    end else if (clr_bry) begin
      s_wbd_bry_o <= 1'b0;
    end else if (load_beat) begin
      s_wbd_dat_o <= m_wbd_dat_i;
      s_wbd_sel_o <= m_wbd_sel_i;
      s_wbd_bry_o <= 1'b1;
    end
  end

`ifdef WB_STAGE_TMO_EN
  localparam int TW = $clog2(TMO_CYC);

  logic [TW-1:0] tmo_cnt;

  // Any slave ack restarts the window; an ack on the terminal cycle beats the timeout.
  assign tmo_hit = busy && !s_wbd_ack_i && (tmo_cnt == TW'(TMO_CYC - 1));

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      tmo_err <= 1'b0;
    end else begin
      tmo_err <= tmo_hit;
      if (!busy || s_wbd_ack_i || tmo_hit) tmo_cnt <= '0;
      else                                 tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign tmo_err = 1'b0;
`endif

  if (RSP_REG != 0) begin : g_rsp_reg
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
        m_wbd_dat_o  <= '0;
        m_wbd_ack_o  <= 1'b0;
        m_wbd_lack_o <= 1'b0;
        err_q        <= 1'b0;
      end else begin
        m_wbd_dat_o  <= s_wbd_dat_i;
        m_wbd_ack_o  <= s_wbd_ack_i;
        m_wbd_lack_o <= s_wbd_lack_i;
        err_q        <= s_wbd_err_i;
      end
    end

    assign m_wbd_err_o = err_q | tmo_err;
  end else begin : g_rsp_byp
    assign m_wbd_dat_o  = s_wbd_dat_i;
    assign m_wbd_ack_o  = s_wbd_ack_i;
    assign m_wbd_lack_o = s_wbd_lack_i;
    assign m_wbd_err_o  = s_wbd_err_i | tmo_err;
  end

endmodule

// File: tb/tb_wb_stage_slice.sv
// Self-checking bench for wb_stage_slice: one registered-response and one bypass instance share stimulus.
// Define WB_STAGE_TMO_EN for both RTL and bench to exercise the timeout path (TMO_CYC=8).
module tb_wb_stage_slice;
  localparam int DW = 32, AW = 32, BLW = 10, TIDW = 4, TMO = 8, SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0]   m_dat, s_dat;
  logic [AW-1:0]   m_adr;
  logic [SW-1:0]   m_sel;
  logic [BLW-1:0]  m_bl;
  logic [TIDW-1:0] m_tid;
  logic m_bry, m_we, m_cyc, m_stb, s_ack, s_lack, s_err;

  logic [DW-1:0] a_m_dat, b_m_dat, a_s_dat, b_s_dat, o_m_dat, o_s_dat;
  logic [AW-1:0] a_s_adr, b_s_adr, o_s_adr;
  logic [SW-1:0] a_s_sel, b_s_sel, o_s_sel;
  logic [BLW-1:0] a_s_bl, b_s_bl, o_s_bl;
  logic [TIDW-1:0] a_s_tid, b_s_tid, o_s_tid;
  logic a_m_ack, a_m_lack, a_m_err, a_s_bry, a_s_we, a_s_cyc, a_s_stb;
  logic b_m_ack, b_m_lack, b_m_err, b_s_bry, b_s_we, b_s_cyc, b_s_stb;
  logic o_m_ack, o_m_lack, o_m_err, o_s_bry, o_s_we, o_s_cyc, o_s_stb;
  logic use_b = 1'b0;

  wb_stage_slice #(.DW(DW), .AW(AW), .BLW(BLW), .TIDW(TIDW), .RSP_REG(1), .TMO_CYC(TMO)) u_reg (
    .clk_i(clk), .rst_n(rst_n),
    .m_wbd_dat_i(m_dat), .m_wbd_adr_i(m_adr), .m_wbd_sel_i(m_sel), .m_wbd_bl_i(m_bl),
    .m_wbd_bry_i(m_bry), .m_wbd_we_i(m_we), .m_wbd_cyc_i(m_cyc), .m_wbd_stb_i(m_stb),
    .m_wbd_tid_i(m_tid),
    .m_wbd_dat_o(a_m_dat), .m_wbd_ack_o(a_m_ack), .m_wbd_lack_o(a_m_lack), .m_wbd_err_o(a_m_err),
    .s_wbd_dat_i(s_dat), .s_wbd_ack_i(s_ack), .s_wbd_lack_i(s_lack), .s_wbd_err_i(s_err),
    .s_wbd_dat_o(a_s_dat), .s_wbd_adr_o(a_s_adr), .s_wbd_sel_o(a_s_sel), .s_wbd_bl_o(a_s_bl),
    .s_wbd_bry_o(a_s_bry), .s_wbd_we_o(a_s_we), .s_wbd_cyc_o(a_s_cyc), .s_wbd_stb_o(a_s_stb),
    .s_wbd_tid_o(a_s_tid)
  );

  wb_stage_slice #(.DW(DW), .AW(AW), .BLW(BLW), .TIDW(TIDW), .RSP_REG(0), .TMO_CYC(TMO)) u_byp (
    .clk_i(clk), .rst_n(rst_n),
    .m_wbd_dat_i(m_dat), .m_wbd_adr_i(m_adr), .m_wbd_sel_i(m_sel), .m_wbd_bl_i(m_bl),
    .m_wbd_bry_i(m_bry), .m_wbd_we_i(m_we), .m_wbd_cyc_i(m_cyc), .m_wbd_stb_i(m_stb),
    .m_wbd_tid_i(m_tid),
    .m_wbd_dat_o(b_m_dat), .m_wbd_ack_o(b_m_ack), .m_wbd_lack_o(b_m_lack), .m_wbd_err_o(b_m_err),
    .s_wbd_dat_i(s_dat), .s_wbd_ack_i(s_ack), .s_wbd_lack_i(s_lack), .s_wbd_err_i(s_err),
    .s_wbd_dat_o(b_s_dat), .s_wbd_adr_o(b_s_adr), .s_wbd_sel_o(b_s_sel), .s_wbd_bl_o(b_s_bl),
    .s_wbd_bry_o(b_s_bry), .s_wbd_we_o(b_s_we), .s_wbd_cyc_o(b_s_cyc), .s_wbd_stb_o(b_s_stb),
    .s_wbd_tid_o(b_s_tid)
  );

  assign o_m_dat  = use_b ? b_m_dat  : a_m_dat;
  assign o_m_ack  = use_b ? b_m_ack  : a_m_ack;
  assign o_m_lack = use_b ? b_m_lack : a_m_lack;
  assign o_m_err  = use_b ? b_m_err  : a_m_err;
  assign o_s_dat  = use_b ? b_s_dat  : a_s_dat;
  assign o_s_adr  = use_b ? b_s_adr  : a_s_adr;
  assign o_s_sel  = use_b ? b_s_sel  : a_s_sel;
  assign o_s_bl   = use_b ? b_s_bl   : a_s_bl;
  assign o_s_tid  = use_b ? b_s_tid  : a_s_tid;
  assign o_s_bry  = use_b ? b_s_bry  : a_s_bry;
  assign o_s_we   = use_b ? b_s_we   : a_s_we;
  assign o_s_cyc  = use_b ? b_s_cyc  : a_s_cyc;
  assign o_s_stb  = use_b ? b_s_stb  : a_s_stb;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_dat = '0; m_adr = '0; m_sel = '0; m_bl = '0; m_tid = '0;
    m_bry = 1'b0; m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
    s_dat = '0; s_ack = 1'b0; s_lack = 1'b0; s_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Cycle vectors: inputs {m_stb,m_bry,s_ack,s_lack,s_err}; outputs after the edge {s_stb,s_bry,m_ack,m_lack,m_err}.
  typedef struct {
    logic [4:0] in;
    logic [4:0] exp;
  } vec_t;

  // Expected master-side response beats with the cycle they must appear on.
  typedef struct {
    logic [DW-1:0] dat;
    logic          lack;
    int            due;
  } rsp_t;

  rsp_t rq[$];

  task automatic run_random_txn(input bit b);
    int bl, mbeat, sbeat, now, wait_cnt, post, lat;
    bit seen, done, exp_ack;
    logic [DW-1:0]   wd[4];
    logic [SW-1:0]   ws[4];
    logic [AW-1:0]   adr;
    logic [TIDW-1:0] tid;
    logic            we;
    bl = $urandom_range(1, 4);
    mbeat = 0; sbeat = 0; now = 0; wait_cnt = 0; post = 0;
    lat = b ? 0 : 1;
    seen = 1'b0; done = 1'b0;
    adr = $urandom;
    tid = TIDW'($urandom_range(0, 15));
    we  = 1'($urandom_range(0, 1));
    for (int i = 0; i < 4; i++) begin
      wd[i] = $urandom;
      ws[i] = SW'($urandom_range(1, 15));
    end
    rq.delete();
    do_reset();
    use_b = b;
    m_adr = adr; m_tid = tid; m_we = we; m_bl = BLW'(bl);
    m_dat = wd[0]; m_sel = ws[0]; m_stb = 1'b1; m_cyc = 1'b1; m_bry = 1'b1;
    for (int c = 0; c < 100 && post < 3; c++) begin
      tick();
      now++;
      if (done) check("rnd_no_reissue", o_s_stb, 1'b0);
      s_ack = 1'b0; s_lack = 1'b0;
      if (!seen && o_s_stb && o_s_bry) begin
        check("rnd_adr", o_s_adr, adr);
        check("rnd_tid", o_s_tid, tid);
        check("rnd_we", o_s_we, we);
        check("rnd_bl", o_s_bl, BLW'(bl));
        check("rnd_wdat", o_s_dat, wd[sbeat]);
        check("rnd_sel", o_s_sel, ws[sbeat]);
        seen = 1'b1;
        wait_cnt = $urandom_range(0, 2);
      end
      if (seen) begin
        if (wait_cnt == 0) begin
          s_ack  = 1'b1;
          s_dat  = $urandom;
          s_lack = (sbeat == bl - 1);
          rq.push_back('{dat: s_dat, lack: s_lack, due: now + lat});
          seen = 1'b0;
          sbeat++;
        end else begin
          wait_cnt--;
        end
      end
      if (o_s_stb && !done) m_cyc = 1'($urandom_range(0, 1));
      #1;
      exp_ack = (rq.size() > 0) && (rq[0].due == now);
      check("rnd_ack", o_m_ack, exp_ack);
      check("rnd_err", o_m_err, 1'b0);
      if (exp_ack) begin
        check("rnd_rdat", o_m_dat, rq[0].dat);
        check("rnd_lack", o_m_lack, rq[0].lack);
        if (rq[0].lack) begin
          m_stb = 1'b0;
          done  = 1'b1;
        end else begin
          mbeat++;
          m_dat = wd[mbeat];
          m_sel = ws[mbeat];
        end
        void'(rq.pop_front());
      end
      if (done) post++;
    end
    check("rnd_complete", done, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[12];
    logic [DW-1:0] rd[4];
    int beat, rsp, refill_lo;

    // Reset state
    do_reset();
    check("rst_a_s_stb", a_s_stb, 1'b0);
    check("rst_a_s_cyc", a_s_cyc, 1'b0);
    check("rst_a_s_adr", a_s_adr, '0);
    check("rst_a_m_ack", a_m_ack, 1'b0);
    check("rst_a_m_err", a_m_err, 1'b0);
    check("rst_b_s_stb", b_s_stb, 1'b0);

    // Single write, stale strobe, back-to-back bl=3 write with error on beat 2 (registered response)
    tbl[0]  = '{5'b11000, 5'b11000};
    tbl[1]  = '{5'b11000, 5'b11000};
    tbl[2]  = '{5'b11110, 5'b00110};
    tbl[3]  = '{5'b11000, 5'b00000};
    tbl[4]  = '{5'b11000, 5'b11000};
    tbl[5]  = '{5'b11100, 5'b10100};
    tbl[6]  = '{5'b11000, 5'b10000};
    tbl[7]  = '{5'b11000, 5'b11000};
    tbl[8]  = '{5'b11001, 5'b00001};
    tbl[9]  = '{5'b11000, 5'b00000};
    tbl[10] = '{5'b00000, 5'b00000};
    tbl[11] = '{5'b00000, 5'b00000};
    use_b = 1'b0;
    m_adr = 32'h1000_0040; m_dat = 32'hA5A5_1234; m_sel = 4'hF; m_bl = 10'd1;
    m_we = 1'b1; m_tid = 4'd3; m_cyc = 1'b1;
    for (int i = 0; i < 12; i++) begin
      {m_stb, m_bry, s_ack, s_lack, s_err} = tbl[i].in;
      if (i == 4) begin m_adr = 32'h1000_0080; m_bl = 10'd3; end
      if (i == 6) m_dat = 32'hBEEF_0002;
      tick();
      check($sformatf("tbl%0d", i), {o_s_stb, o_s_bry, o_m_ack, o_m_lack, o_m_err}, tbl[i].exp);
      check($sformatf("tbl%0d_cyc", i), o_s_cyc, tbl[i].exp[4]);
      if (!tbl[i].exp[4]) check($sformatf("tbl%0d_adr_clr", i), o_s_adr, '0);
      if (i == 0) begin
        check("sw_adr", o_s_adr, 32'h1000_0040);
        check("sw_dat", o_s_dat, 32'hA5A5_1234);
        check("sw_sel", o_s_sel, 4'hF);
        check("sw_bl", o_s_bl, 10'd1);
        check("sw_we", o_s_we, 1'b1);
        check("sw_tid", o_s_tid, 4'd3);
      end
      if (i == 7) begin
        check("err_beat2_dat", o_s_dat, 32'hBEEF_0002);
        check("err_beat2_adr", o_s_adr, 32'h1000_0080);
      end
    end

    // Read burst bl=4, registered response
    rd[0] = 32'h11; rd[1] = 32'h22; rd[2] = 32'h33; rd[3] = 32'h44;
    beat = 0; rsp = 0; refill_lo = 0;
    do_reset();
    use_b = 1'b0;
    m_adr = 32'h2000_0100; m_tid = 4'd5; m_bl = 10'd4; m_we = 1'b0;
    m_stb = 1'b1; m_cyc = 1'b1; m_bry = 1'b1;
    for (int n = 0; n < 40 && rsp < 4; n++) begin
      tick();
      s_ack = 1'b0; s_lack = 1'b0;
      if (o_s_stb) begin
        check("burst_adr", o_s_adr, 32'h2000_0100);
        check("burst_tid", o_s_tid, 4'd5);
        if (!o_s_bry) refill_lo++;
      end
      if (o_m_ack) begin
        check($sformatf("burst_rdat%0d", rsp), o_m_dat, rd[rsp]);
        check($sformatf("burst_lack%0d", rsp), o_m_lack, (rsp == 3));
        if (o_m_lack) m_stb = 1'b0;
        rsp++;
      end
      if (o_s_stb && o_s_bry && beat < 4) begin
        s_ack = 1'b1; s_dat = rd[beat]; s_lack = (beat == 3);
        beat++;
      end
    end
    check("burst_beats", rsp, 4);
    check("burst_refill_cycles", refill_lo, 6);
    tick();
    check("burst_idle", o_s_stb, 1'b0);

    // Back-to-back singles, bypass response: new strobe 2 cycles after lack
    do_reset();
    use_b = 1'b1;
    m_adr = 32'h3000_0000; m_stb = 1'b1; m_cyc = 1'b1; m_bry = 1'b1; m_bl = 10'd1;
    tick();
    check("b2b_first_stb", o_s_stb, 1'b1);
    s_ack = 1'b1; s_lack = 1'b1; s_dat = 32'h77;
    #1;
    check("b2b_comb_ack", {o_m_ack, o_m_lack}, 2'b11);
    check("b2b_comb_dat", o_m_dat, 32'h77);
    m_adr = 32'h3000_0004;
    tick();
    s_ack = 1'b0; s_lack = 1'b0;
    check("b2b_gap", o_s_stb, 1'b0);
    tick();
    check("b2b_second_stb", o_s_stb, 1'b1);
    check("b2b_second_adr", o_s_adr, 32'h3000_0004);

`ifdef WB_STAGE_TMO_EN
    // Timeout: slave never acks
    do_reset();
    use_b = 1'b0;
    m_adr = 32'h4000_0000; m_stb = 1'b1; m_cyc = 1'b1; m_bry = 1'b1; m_bl = 10'd1;
    tick();
    for (int k = 1; k < TMO; k++) begin
      tick();
      check($sformatf("tmo_wait%0d", k), {o_s_stb, o_m_err}, 2'b10);
    end
    tick();
    check("tmo_drop", {o_s_stb, o_s_cyc, o_s_bry}, 3'b000);
    check("tmo_err_pulse", o_m_err, 1'b1);
    m_stb = 1'b0;
    tick();
    check("tmo_err_single", o_m_err, 1'b0);
    tick();
    m_stb = 1'b1;
    tick();
    check("tmo_next_accept", o_s_stb, 1'b1);
    for (int k = 1; k < TMO; k++) tick();
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    check("tmo_ack_wins", {o_s_stb, o_s_bry, o_m_err}, 3'b100);
`else
    // No timeout: the stage waits indefinitely
    do_reset();
    use_b = 1'b0;
    m_adr = 32'h4000_0000; m_stb = 1'b1; m_cyc = 1'b1; m_bry = 1'b1; m_bl = 10'd1;
    repeat (300) tick();
    check("notmo_hold", {o_s_stb, o_m_err}, 2'b10);
`endif

    // Async reset mid-burst
    do_reset();
    use_b = 1'b0;
    m_adr = 32'h5000_0000; m_bl = 10'd4; m_stb = 1'b1; m_cyc = 1'b1; m_bry = 1'b1;
    tick();
    s_ack = 1'b1; s_dat = 32'h55;
    tick();
    s_ack = 1'b0;
    check("arst_pre_ack", o_m_ack, 1'b1);
    #2 rst_n = 1'b0;
    m_stb = 1'b0;
    #1;
    check("arst_s_ctl", {o_s_stb, o_s_cyc, o_s_bry}, 3'b000);
    check("arst_s_adr", o_s_adr, '0);
    check("arst_m_rsp", {o_m_ack, o_m_lack, o_m_err}, 3'b000);
    check("arst_m_dat", o_m_dat, '0);
    #3 rst_n = 1'b1;
    repeat (2) tick();
    check("arst_idle", o_s_stb, 1'b0);
    m_stb = 1'b1; m_bry = 1'b0;
    tick();
    check("arst_no_bry", o_s_stb, 1'b0);
    m_bry = 1'b1;
    tick();
    check("arst_fresh", o_s_stb, 1'b1);

    // Randomized transactions on both response modes
    for (int t = 0; t < 40; t++) run_random_txn(1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
